// File: rtl/alu.sv
// 16-bit ALU datapath slice. Combinational; the divider uses it in
// subtract mode, where cout=1 signals that no borrow occurred.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] o,
  output logic             cout
);

  logic [WIDTH:0] sum;

  // op: 00 add, 01 subtract (i0 - i1), 10 and, 11 or
  always_comb begin
    sum = '0;
    case (op)
      2'b00:   sum = {1'b0, i0} + {1'b0, i1};
      2'b01:   sum = {1'b0, i0} + {1'b0, ~i1} + (WIDTH+1)'(1);
      2'b10:   sum = {1'b0, i0 & i1};
      default: sum = {1'b0, i0 | i1};
    endcase
    o    = sum[WIDTH-1:0];
    cout = sum[WIDTH];
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider. One quotient bit per cycle, using the shared
// ALU subtractor as the trial-subtract/compare. Start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, next_state;
  logic [WIDTH-1:0] d_reg, q_reg, r_reg;
  logic [CW-1:0]    cnt;

  // Trial subtract of the shifted partial remainder against the divisor
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] diff, r_next, q_next;
  logic             no_borrow, take;

  assign s = {r_reg, q_reg[WIDTH-1]};

  alu #(.WIDTH(WIDTH)) u_alu (
    .i0   (s[WIDTH-1:0]),
    .i1   (d_reg),
    .op   (2'b01),
    .o    (diff),
    .cout (no_borrow)
  );

  // A set S[WIDTH] means S exceeds any divisor, so the subtract always takes
  // and the truncated difference is still exact.
  assign take   = s[WIDTH] | no_borrow;
  assign r_next = take ? diff : s[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], take};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Datapath: operand latch, restoring steps, result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor != '0) begin
            d_reg       <= divisor;
            q_reg       <= dividend;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
          end else begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes the expected result and
// done cycle; an independent monitor checks every done pulse against it.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      tests = tests + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_done cyc=%0d q=%h r=%h z=%b", cyc, quotient, remainder, div_by_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z || cyc != e.cyc) begin
          fails = fails + 1;
          $display("FAIL result got q=%h r=%h z=%b cyc=%0d want q=%h r=%h z=%b cyc=%0d",
                   quotient, remainder, div_by_zero, cyc, e.q, e.r, e.z, e.cyc);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int issue);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.cyc = issue + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.cyc = issue + W + 1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests = tests + 1;
    if (got !== want) begin
      fails = fails + 1;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Wait (bounded) for an IDLE cycle; leaves us #1 after a posedge
  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL idle_timeout busy=%b want=0", busy);
    end
  endtask

  // Issue one operation in the current IDLE cycle and record the expectation
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b, cyc));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    issue(a, b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_q", quotient, 16'd0);
    check("rst_r", remainder, 16'd0);
    check("rst_z", {15'd0, div_by_zero}, 16'd0);
    rst = 1'b0;

    // Basic op with busy from cycle 1
    wait_idle();
    issue(16'd100, 16'd7);
    check("busy_c1", {15'd0, busy}, 16'd1);
    drain();

    // Boundary operands
    do_op(16'hFFFE, 16'h8000);
    do_op(16'hFFFF, 16'h0001);
    do_op(16'd3, 16'd10);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'd5, 16'd0);
    do_op(16'd9, 16'd3);
    drain();

    // Start while busy is ignored; then back-to-back in the IDLE cycle after done
    wait_idle();
    issue(16'd100, 16'd7);
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    repeat (8) begin @(posedge clk); #1; end
    start = 1'b0;
    do_op(16'd50, 16'd5);
    drain();

    // Async reset mid-operation discards the result
    wait_idle();
    issue(16'd1000, 16'd3);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_done", {15'd0, done}, 16'd0);
    check("mid_rst_q", quotient, 16'd0);
    check("mid_rst_r", remainder, 16'd0);
    check("mid_rst_z", {15'd0, div_by_zero}, 16'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    do_op(16'd1000, 16'd3);
    drain();

    // Randomized operands, some zero/small divisors
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom_range(16'h8000, 16'hFFFF));
        default: b = W'($urandom);
      endcase
      do_op(a, b);
    end
    drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
